// File: rtl/insn_decode_queue.sv
// Buffered instruction decode stage: a DEPTH-word FIFO of tagged 64-bit words that
// presents one decoded half-instruction per output handshake (left half, then right half).
module insn_decode_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_word,
  input  logic                     in_pe,
  input  logic                     flush,
  input  logic                     flush_tkk,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_tkk,
  output logic                     out_pe,
  output logic [3:0]               ir,
  output logic                     ir15,
  output logic [7:0]               op,
  output logic                     extop,
  output logic [ADDR_W-1:0]        addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [64:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           half_q, half_d;
  logic           pend_q, pend_d;

  logic push, hs, pop, empty, full;

  // Fullness comes only from registered count, so out_ready never reaches in_ready.
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && half_q;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    half_d   = half_q;
    pend_d   = pend_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      half_d   = 1'b0;
      pend_d   = flush_tkk;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      if (hs) half_d = !half_q;
      // A restart-at-right request applies to the first word written after the flush.
      if (push && pend_q) begin
        half_d = 1'b1;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_word, in_pe};
  end

  logic [64:0] head;
  logic [64:1] dc;
  logic        pe;
  logic [3:0]  ir_v;
  logic [7:0]  bop, xop;
  logic [19:0] a20;

  // Bits are numbered 64..1 to match the instruction-set documentation.
  always_comb begin
    head = mem_q[rd_ptr_q];
    dc   = head[64:1];
    pe   = head[0];
    ir_v = '0;
    bop  = '0;
    a20  = '0;
    if (!pe) begin
      ir_v = half_q ? dc[32:29] : dc[64:61];
      bop  = half_q ? dc[28:21] : dc[60:53];
      a20  = half_q ? dc[20:1]  : dc[52:33];
    end else if (!half_q) begin
      ir_v = {dc[64], dc[59:57]};
      if (dc[56]) begin
        bop = {dc[56:52], 3'b000};
        a20 = {5'd0, dc[51:37]};
      end else begin
        bop = dc[56:49];
        a20 = {5'd0, {3{dc[55]}}, dc[48:37]};
      end
    end else begin
      ir_v = dc[36:33];
      if (dc[32]) begin
        bop = {dc[32:28], 3'b000};
        a20 = {5'd0, dc[27:13]};
      end else begin
        bop = dc[32:25];
        a20 = {5'd0, {3{dc[31]}}, dc[24:13]};
      end
    end
    xop = half_q ? dc[20:13] : dc[52:45];
  end

  assign out_tkk = half_q;
  assign out_pe  = pe;
  assign ir      = ir_v;
  assign ir15    = (ir_v == 4'hF);
  assign extop   = !pe && (bop == 8'h3F);
  assign op      = extop ? xop : bop;
  assign addr    = ADDR_W'(a20);

endmodule

// File: doc/insn_decode_queue.md
Name: insn_decode_queue

Overview:
- Buffered instruction decode stage that sits between instruction fetch and the micro-sequencer. It is the sequential, parametrised successor to the combinational half-word decoder.
- Accepts 64-bit instruction words over a valid/ready handshake and stores them in a DEPTH-entry FIFO. Each word carries its own compatibility-mode tag.
- Presents one decoded half-instruction per handshake: the left half first, then the right half.
- Supports pipeline flush with restart at either half.

Parameters:
DEPTH, 2, FIFO depth in words; power of two, at least 2.
ADDR_W, 20, width of addr output; at least 20; decoded address is zero-extended.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  fetch presents a word.
in_ready  output  1  queue can accept a word.
in_word  input  64  instruction word; bits numbered 64..1 (bit 1 = LSB).
in_pe  input  1  BESM-6 compatibility tag, stored with the word.
flush  input  1  discard all queued words.
flush_tkk  input  1  with flush: the next accepted word starts at its right half.
out_valid  output  1  decoded half-instruction available.
out_ready  input  1  consumer takes the half-instruction.
out_tkk  output  1  0 = left half, 1 = right half.
out_pe  output  1  tag of the head word.
ir  output  4  modifier index.
ir15  output  1  ir == 15 (stack mode).
op  output  8  opcode.
extop  output  1  extended opcode flag.
addr  output  ADDR_W  address field.
count  output  $clog2(DEPTH)+1  words currently held.

Behaviour:
Reset (async, reset_n=0):
- FIFO empty, half flag = 0, pending-right flag = 0.
- out_valid=0, in_ready=1, count=0.
- Decode outputs are driven from the head slot and are don't-care while out_valid=0.
- The bench checks only in_ready, out_valid and count during reset.

Push and pop:
- in_ready = !full && !flush.
- A push happens when in_valid && in_ready. It writes {in_word, in_pe} at the tail.
- out_valid = !empty. Outputs are combinational from the head entry plus the half flag.
- A word accepted in cycle N is visible on the outputs in cycle N+1.
- An out handshake with half=0 sets half=1; the word stays at the head.
- An out handshake with half=1 pops the word and clears half to 0.
- Push and pop may occur in the same cycle; count is unchanged.
- When full, in_ready=0 even if a pop occurs that cycle. No combinational path from out_ready to in_ready.
- When empty, no pop occurs and half is held.
- Pointers wrap modulo DEPTH.
- The consumer must hold out_ready meaningfully only while out_valid=1.

Flush:
- Highest priority. The FIFO empties next cycle and count=0.
- Any simultaneous push is dropped, since in_ready=0 during flush.
- half := 0 and pending-right := flush_tkk.
- On the next accepted word with pending-right=1, half is loaded to 1 as that word is written, and pending-right is cleared. The first output of that word is its right half.
- If pending-right=1 and a second flush arrives, the second flush's flush_tkk overrides.

Decode (pe = head tag, tkk = half):
- ir:
  - pe=0: left = dc[64:61]; right = dc[32:29].
  - pe=1: left = {dc[64], dc[59:57]}; right = dc[36:33].
- ir15 = (ir == 15).
- Base opcode bop:
  - pe=0: left = dc[60:53]; right = dc[28:21].
  - pe=1, left: if dc[56], bop = {dc[56:52], 000}; else bop = dc[56:49].
  - pe=1, right: if dc[32], bop = {dc[32:28], 000}; else bop = dc[32:25].
- Extended opcode xop: left = dc[52:45]; right = dc[20:13].
- extop = !pe && bop == 8'h3F. op = extop ? xop : bop.
- addr, before zero-extension to ADDR_W:
  - pe=0: left = dc[52:33]; right = dc[20:1].
  - pe=1, left: if dc[56], {5'd0, dc[51:37]}; else {5'd0, {3{dc[55]}}, dc[48:37]}.
  - pe=1, right: if dc[32], {5'd0, dc[27:13]}; else {5'd0, {3{dc[31]}}, dc[24:13]}.

Test Plan:
1. Reset, then push word 0x51201234_F3FA7000 with pe=0; out_ready=1.
   - Cycle 1: tkk=0, ir=5, op=0x12, extop=0, addr=0x01234.
   - Cycle 2: tkk=1, ir=15, ir15=1, op=0xA7, extop=1, addr=0xA7000.
   - Then out_valid=0 and count=0.
2. Hold out_ready=0 and push DEPTH words.
   - count=DEPTH, in_ready=0, and the outputs stay stable.
   - Release out_ready: 2*DEPTH halves emerge in order, and in_ready rises the cycle after the first pop.
3. Steady stream with simultaneous push and pop.
   - count constant, no lost or duplicated halves; checked across at least 3 pointer wraps.
4. flush=1, flush_tkk=1 while 2 words are queued, then push the test-1 word.
   - count=0 after the flush.
   - The first output is tkk=1, op=0xA7, followed directly by the next word's left half.
5. pe=1 word with dc[56]=1, dc[51:37]=0x1ABC.
   - Left half: op={dc[56:52],000}, addr=0x01ABC, extop=0 even though bop is 0x3F-capable.
6. Assert reset_n=0 mid-stream with count=1 and half=1.
   - Immediately out_valid=0, count=0.
   - The next word starts at its left half.
